// File: rtl/rc4_frame_packer.sv
// rc4_frame_packer: buffers an unthrottled ciphertext byte stream into messages and
// emits each one as a SYNC/LEN/payload/checksum frame over a valid/ready link.
module rc4_frame_packer #(
  parameter int          DEPTH    = 16,
  parameter int          MAX_LEN  = 16,
  parameter int          LQ_DEPTH = 4,
  parameter logic [7:0]  SYNC     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       overflow,
  output logic       busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LQ_DEPTH);
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_LEN, S_PAY, S_CSUM} state_t;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    lq_q [LQ_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, msg_start_q, msg_start_d;
  logic          full_q, full_d;
  logic [7:0]    msg_cnt_q, msg_cnt_d, cnt_inc;
  logic          err_q, err_d, err_now, ovf_q, ovf_d;
  logic [LW-1:0] lq_wr_q, lq_rd_q;
  logic [LW:0]   lq_cnt_q, lq_cnt_d;
  state_t        state_q, state_d;
  logic [7:0]    out_data_q, out_data_d, len_q, len_d, rem_q, rem_d, csum_q, csum_d;
  logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic          wr_en, close, lq_full, commit, fire, avail, start, pop, rd_inc;
  logic          lq_push, lq_pop, lq_empty, active;
  logic [7:0]    next_len, rd_byte;
  assign active   = state_q != S_IDLE;
  assign lq_empty = lq_cnt_q == '0;
  assign wr_en    = in_valid & ~full_q;
  assign cnt_inc  = msg_cnt_q + 8'(wr_en);
  assign close    = in_valid & (in_last | (wr_en & (cnt_inc == 8'(MAX_LEN))));
  assign err_now  = err_q | (in_valid & full_q);
  // the frame being transmitted still occupies one length slot until its checksum goes out
  assign lq_full  = ({1'b0, lq_cnt_q} + (LW+2)'(active)) >= (LW+2)'(LQ_DEPTH);
  assign commit   = close & ~err_now & ~lq_full;
  assign wr_ptr_d    = (close & ~commit) ? msg_start_q : wr_ptr_q + (AW+1)'(wr_en);
  assign msg_start_d = commit ? wr_ptr_q + (AW+1)'(1) : msg_start_q;
  assign msg_cnt_d   = close ? '0 : cnt_inc;
  assign err_d       = ~close & err_now;
  assign ovf_d       = ovf_q | (in_valid & full_q) | (close & ~commit);
  assign rd_ptr_d    = rd_ptr_q + (AW+1)'(rd_inc);
  assign full_d      = (wr_ptr_d - rd_ptr_d) == (AW+1)'(DEPTH);
  assign fire     = out_valid_q & out_ready;
  assign avail    = ~lq_empty | commit;
  assign next_len = lq_empty ? cnt_inc : lq_q[lq_rd_q];
  assign rd_byte  = mem_q[rd_ptr_q[AW-1:0]];
  assign lq_pop   = pop & ~lq_empty;
  assign lq_push  = commit & ~(pop & lq_empty);
  assign lq_cnt_d = lq_cnt_q + (LW+1)'(lq_push) - (LW+1)'(lq_pop);
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    len_d       = len_q;
    rem_d       = rem_q;
    csum_d      = csum_q;
    start       = 1'b0;
    rd_inc      = 1'b0;
    case (state_q)
      S_IDLE: start = avail;
      S_SYNC: if (fire) begin
        state_d    = S_LEN;
        out_data_d = len_q;
      end
      S_LEN: if (fire) begin
        state_d    = S_PAY;
        out_data_d = rd_byte;
        rd_inc     = 1'b1;
        rem_d      = len_q - 8'd1;
        csum_d     = csum_q ^ rd_byte;
      end
      S_PAY: if (fire) begin
        state_d    = (rem_q == '0) ? S_CSUM : S_PAY;
        out_data_d = (rem_q == '0) ? csum_q : rd_byte;
        out_last_d = rem_q == '0;
        rd_inc     = rem_q != '0;
        rem_d      = (rem_q == '0) ? rem_q : rem_q - 8'd1;
        csum_d     = (rem_q == '0) ? csum_q : csum_q ^ rd_byte;
      end
      S_CSUM: if (fire) begin
        start       = avail;
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
    pop = start;
    if (start) begin
      state_d     = S_SYNC;
      out_valid_d = 1'b1;
      out_data_d  = SYNC;
      out_last_d  = 1'b0;
      len_d       = next_len;
      csum_d      = next_len;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    if (lq_push) lq_q[lq_wr_q] <= cnt_inc;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      msg_start_q <= '0;
      full_q      <= 1'b0;
      msg_cnt_q   <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      lq_wr_q     <= '0;
      lq_rd_q     <= '0;
      lq_cnt_q    <= '0;
      state_q     <= S_IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      len_q       <= '0;
      rem_q       <= '0;
      csum_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      msg_start_q <= msg_start_d;
      full_q      <= full_d;
      msg_cnt_q   <= msg_cnt_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      lq_wr_q     <= lq_wr_q + LW'(lq_push);
      lq_rd_q     <= lq_rd_q + LW'(lq_pop);
      lq_cnt_q    <= lq_cnt_d;
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      csum_q      <= csum_d;
    end
  end
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign overflow  = ovf_q;
  assign busy      = (wr_ptr_q != rd_ptr_q) | active;
endmodule

// File: tb/tb_rc4_frame_packer.sv
// tb_rc4_frame_packer: directed stimulus; expected frames are built from the message
// contents and checked byte by byte on every transfer, plus stall stability checks.
module tb_rc4_frame_packer;
  localparam logic [7:0] SYNC = 8'hA5;
  logic       clk = 0, rst = 0;
  logic [7:0] in_data = 0;
  logic       in_valid = 0, in_last = 0, out_ready = 0;
  logic [7:0] out_data;
  logic       out_valid, out_last, overflow, busy;
  int         checks = 0, errors = 0;
  logic [7:0] exp_d[$];
  logic       exp_l[$];
  logic       rdy = 0, tog = 0, b2b_arm = 0;
  rc4_frame_packer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .overflow(overflow), .busy(busy)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = tog ? ~out_ready : rdy;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  function automatic logic [7:0] csum_of(input logic [7:0] p[$]);
    logic [7:0] c;
    c = 8'(p.size());
    foreach (p[i]) c ^= p[i];
    return c;
  endfunction
  task automatic expect_frame(input logic [7:0] p[$]);
    exp_d.push_back(SYNC);         exp_l.push_back(1'b0);
    exp_d.push_back(8'(p.size())); exp_l.push_back(1'b0);
    foreach (p[i]) begin
      exp_d.push_back(p[i]);
      exp_l.push_back(1'b0);
    end
    exp_d.push_back(csum_of(p));   exp_l.push_back(1'b1);
  endtask
  task automatic send_bytes(input logic [7:0] p[$], input bit lst);
    foreach (p[i]) begin
      @(posedge clk);
      #1;
      in_data  = p[i];
      in_valid = 1'b1;
      in_last  = lst && (i == p.size() - 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask
  task automatic drain(input int budget);
    int n = 0;
    while ((exp_d.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("drain_left", exp_d.size(), 0);
    chk("drain_busy", busy, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    exp_d.delete();
    exp_l.delete();
    repeat (2) @(negedge clk);
    rst = 1;
  endtask
  // compare process: every accepted byte against the expected frame stream
  initial begin
    logic       stall, pend, el;
    logic [7:0] sd, ed;
    logic       sl;
    stall = 0; pend = 0; sd = 0; sl = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall = 0;
        pend  = 0;
      end else begin
        if (pend) begin
          checks++;
          if (!(out_valid && out_data == SYNC)) begin
            errors++;
            $display("FAIL b2b valid=%0b data=%0h required valid=1 data=%0h", out_valid, out_data, SYNC);
          end
          pend = 0;
        end
        if (stall) begin
          checks++;
          if (!out_valid || out_data !== sd || out_last !== sl) begin
            errors++;
            $display("FAIL hold valid=%0b data=%0h last=%0b required data=%0h last=%0b", out_valid, out_data, out_last, sd, sl);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_d.size() == 0) begin
            errors++;
            $display("FAIL extra data=%0h last=%0b required none", out_data, out_last);
          end else begin
            ed = exp_d.pop_front();
            el = exp_l.pop_front();
            if (out_data !== ed || out_last !== el) begin
              errors++;
              $display("FAIL byte data=%0h last=%0b required data=%0h last=%0b", out_data, out_last, ed, el);
            end
          end
          if (out_last && b2b_arm) begin
            pend    = 1;
            b2b_arm = 0;
          end
        end
        stall = out_valid && !out_ready;
        sd    = out_data;
        sl    = out_last;
      end
    end
  end
  initial begin
    logic [7:0] m[$], m2[$], lit[$];
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1;
    // basic frame
    @(negedge clk);
    rdy = 1;
    m = {8'h05, 8'h0A, 8'h14, 8'h1E, 8'h28};
    chk("t1_csum", csum_of(m), 8'h28);
    expect_frame(m);
    lit = {8'hA5, 8'h05, 8'h05, 8'h0A, 8'h14, 8'h1E, 8'h28, 8'h28};
    foreach (lit[i]) chk("t1_model", exp_d[i], lit[i]);
    chk("t1_model_last", exp_l[7], 1);
    send_bytes(m, 1);
    drain(100);
    chk("t1_ovf", overflow, 0);
    // backpressure
    @(negedge clk);
    tog = 1;
    expect_frame(m);
    send_bytes(m, 1);
    drain(100);
    @(negedge clk);
    tog = 0;
    rdy = 1;
    // MAX_LEN auto-close, back-to-back frames
    m.delete();
    for (int i = 0; i < 16; i++) m.push_back(8'(i));
    m2 = {8'h10, 8'h11};
    chk("t3_csum1", csum_of(m), 8'h10);
    chk("t3_csum2", csum_of(m2), 8'h03);
    expect_frame(m);
    expect_frame(m2);
    b2b_arm = 1;
    send_bytes(m, 0);
    repeat (8) @(posedge clk);
    send_bytes(m2, 1);
    drain(200);
    chk("t3_b2b_seen", b2b_arm, 0);
    chk("t3_ovf", overflow, 0);
    // payload overflow
    @(negedge clk);
    rdy = 0;
    m.delete();
    m2.delete();
    for (int i = 1; i <= 20; i++) m.push_back(8'(i));
    for (int i = 1; i <= 16; i++) m2.push_back(8'(i));
    chk("t4_csum", csum_of(m2), 8'h00);
    expect_frame(m2);
    send_bytes(m, 1);
    repeat (3) @(posedge clk);
    #2;
    chk("t4_ovf", overflow, 1);
    chk("t4_stall_valid", out_valid, 1);
    chk("t4_stall_data", out_data, 8'hA5);
    @(negedge clk);
    rdy = 1;
    drain(200);
    chk("t4_ovf_sticky", overflow, 1);
    // length queue full
    do_reset();
    rdy = 0;
    #1;
    chk("t5_ovf_clr", overflow, 0);
    m = {8'hAA};
    chk("t5_csum", csum_of(m), 8'hAB);
    foreach (lit[i]) lit[i] = 0;
    lit = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    foreach (lit[i]) begin
      m = {lit[i]};
      if (i < 4) expect_frame(m);
      send_bytes(m, 1);
    end
    repeat (3) @(posedge clk);
    #2;
    chk("t5_ovf", overflow, 1);
    @(negedge clk);
    rdy = 1;
    drain(200);
    // reset mid-frame
    do_reset();
    rdy = 1;
    m = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    expect_frame(m);
    send_bytes(m, 1);
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_last", out_last, 0);
    chk("t6_data", out_data, 0);
    chk("t6_busy", busy, 0);
    exp_d.delete();
    exp_l.delete();
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (5) @(negedge clk);
    chk("t6_quiet_valid", out_valid, 0);
    chk("t6_quiet_busy", busy, 0);
    m = {8'h3C, 8'hC3};
    expect_frame(m);
    send_bytes(m, 1);
    drain(100);
    chk("t6_ovf", overflow, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
